ws2812b_multi_pixel_capture: RTL



---
 rtl/ws2812b_multi_pixel_capture_if.sv | 10 +
 rtl/ws2812b_multi_pixel_capture.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/ws2812b_multi_pixel_capture_if.sv
// Register bus between the TinyQV core and the WS2812B capture peripheral.
interface ws2812b_multi_pixel_capture_if;
  logic [3:0] address;
  logic       data_write;
  logic [7:0] data_in;
  logic [7:0] data_out;

  modport master (output address, data_write, data_in, input data_out);
  modport slave  (input address, data_write, data_in, output data_out);
endinterface

// File: rtl/ws2812b_multi_pixel_capture.sv
// WS2812B chain sniffer: captures the first NUM_PIXELS pixels of each frame into a
// double buffer and forwards the remaining bits on uo_out like a normal chain member.
module ws2812b_multi_pixel_capture #(
  parameter int NUM_PIXELS      = 4,
  parameter int BYTES_PER_PIXEL = 3,
  parameter int DEF_THRESHOLD   = 38,
  parameter int DEF_IDLE        = 3840
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  ws2812b_multi_pixel_capture_if.slave bus
);
  localparam int TOTAL = NUM_PIXELS * BYTES_PER_PIXEL;
  localparam int IW    = $clog2(TOTAL);
  localparam int PW    = $clog2(TOTAL + 1);

  typedef enum logic [1:0] {ST_WAIT = 2'd0, ST_CAPTURE = 2'd1, ST_PASS = 2'd2} state_t;
  state_t state, state_nx;

  logic [2:0]  din_sel;
  logic        din, din_q, rise, fall;
  logic [15:0] hi_cnt, lo_cnt, thr, idle_v, thr_sh, idle_sh;
  logic        armed, idle_evt, bit_v, byte_done;
  logic [7:0]  shreg, byte_v, frame_cnt;
  logic [2:0]  bit_cnt;
  logic [PW-1:0] byte_ptr;
  logic [3:0]  pix_idx;
  logic        ready, overrun, partial;
  logic        complete, set_rdy, set_ovr, set_part;
  logic [2:0]  clr;
  logic [TOTAL-1:0][7:0] work, vis;

  assign din       = ui_in[din_sel];
  assign rise      = din & ~din_q;
  assign fall      = ~din & din_q;
  assign bit_v     = hi_cnt > thr;
  assign byte_v    = {shreg[6:0], bit_v};
  assign byte_done = fall & (bit_cnt == 3'd7);
  // Fires once per low stretch; armed is only restored by the next rising edge.
  assign idle_evt  = armed & ~din & (lo_cnt == idle_v);

  assign complete  = (byte_ptr == PW'(TOTAL));
  assign set_rdy   = idle_evt & complete;
  assign set_ovr   = set_rdy & ready;
  assign set_part  = idle_evt & ~complete & (byte_ptr != '0);
  assign clr       = (bus.data_write && bus.address == 4'h5) ? bus.data_in[2:0] : 3'b000;

  assign uo_out    = (state == ST_PASS) ? {8{din_q}} : 8'h00;

  always_comb begin
    state_nx = state;
    case (state)
      ST_WAIT:    if (rise) state_nx = ST_CAPTURE;
      ST_CAPTURE: if (byte_done && byte_ptr == PW'(TOTAL - 1)) state_nx = ST_PASS;
      ST_PASS:    ;
      default:    state_nx = ST_WAIT;
    endcase
    if (idle_evt) state_nx = ST_WAIT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_WAIT;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_q <= 1'b0;  hi_cnt <= '0;  lo_cnt <= '0;  armed <= 1'b1;
      shreg <= '0;    bit_cnt <= '0; byte_ptr <= '0;
      work <= '0;     vis <= '0;     frame_cnt <= '0;
      ready <= 1'b0;  overrun <= 1'b0; partial <= 1'b0;
      pix_idx <= '0;  din_sel <= 3'd1;
      thr <= 16'(DEF_THRESHOLD);  thr_sh <= 16'(DEF_THRESHOLD);
      idle_v <= 16'(DEF_IDLE);    idle_sh <= 16'(DEF_IDLE);
    end else begin
      din_q <= din;
      if (din) begin
        lo_cnt <= '0;
        if (hi_cnt != 16'hFFFF) hi_cnt <= hi_cnt + 16'd1;
      end else begin
        hi_cnt <= '0;
        if (lo_cnt != 16'hFFFF) lo_cnt <= lo_cnt + 16'd1;
      end

      if (rise)          armed <= 1'b1;
      else if (idle_evt) armed <= 1'b0;

      if (idle_evt) begin
        shreg <= '0;
        bit_cnt <= '0;
      end else if (fall) begin
        shreg <= byte_v;
        bit_cnt <= bit_cnt + 3'd1;
      end

      if (idle_evt) byte_ptr <= '0;
      else if (state == ST_CAPTURE && byte_done) begin
        work[IW'(byte_ptr)] <= byte_v;
        byte_ptr <= byte_ptr + PW'(1);
      end

      if (set_rdy) begin
        vis <= work;
        frame_cnt <= frame_cnt + 8'd1;
      end
      // A set event in the same cycle outranks a software clear.
      ready   <= set_rdy  | (ready   & ~clr[0]);
      overrun <= set_ovr  | (overrun & ~clr[1]);
      partial <= set_part | (partial & ~clr[2]);

      if (bus.data_write) begin
        case (bus.address)
          4'h0: pix_idx       <= bus.data_in[3:0];
          4'h6: idle_sh[7:0]  <= bus.data_in;
          4'h7: idle_sh[15:8] <= bus.data_in;
          4'h8: thr_sh[7:0]   <= bus.data_in;
          4'h9: thr_sh[15:8]  <= bus.data_in;
          4'hA: begin
            thr    <= thr_sh;
            idle_v <= idle_sh;
          end
          4'hB: din_sel <= bus.data_in[2:0];
          default: ;
        endcase
      end
    end
  end

  int sel_b, idx;
  always_comb begin
    bus.data_out = 8'h00;
    sel_b = 0;
    idx = 0;
    case (bus.address)
      4'h0: bus.data_out = {4'b0000, pix_idx};
      4'h1, 4'h2, 4'h3, 4'h4: begin
        sel_b = int'(bus.address) - 1;
        idx   = int'(pix_idx) * BYTES_PER_PIXEL + sel_b;
        if (int'(pix_idx) < NUM_PIXELS && sel_b < BYTES_PER_PIXEL)
          bus.data_out = vis[IW'(idx)];
      end
      4'h5: bus.data_out = {3'b000, state, partial, overrun, ready};
      4'h6: bus.data_out = idle_sh[7:0];
      4'h7: bus.data_out = idle_sh[15:8];
      4'h8: bus.data_out = thr_sh[7:0];
      4'h9: bus.data_out = thr_sh[15:8];
      4'hB: bus.data_out = {5'b00000, din_sel};
      4'hC: bus.data_out = frame_cnt;
      default: ;
    endcase
  end
endmodule
